// File: rtl/rayforge_q_pkg.sv
// Shared Q8.4 constants, FSM state codes and the bit-pair square-root step used by
// both the combinational and iterative (NORMALIZE_SQRT_ITER_EN) root implementations.
package rayforge_q_pkg;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned FRAC   = 4;
  localparam int unsigned ACC_W  = 2 * WIDTH;
  localparam int unsigned SQRT_W = 8;
  localparam int unsigned RAD_W  = 16;
  localparam int          MAX_Q  = 2047;
  localparam int          MIN_Q  = -2048;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StSq   = 3'd1;
  localparam state_t StRoot = 3'd2;
  localparam state_t StDiv  = 3'd3;
  localparam state_t StDone = 3'd4;

  typedef struct packed {
    logic [9:0]        rem;
    logic [SQRT_W-1:0] root;
  } sqrt_step_t;

  // One restoring step: bring down the next radicand bit pair and try root*4+1.
  function automatic sqrt_step_t sqrt_step(input logic [9:0] rem, input logic [SQRT_W-1:0] root,
                                           input logic [1:0] pair);
    sqrt_step_t  res;
    logic [11:0] cur;
    logic [11:0] trial;
    cur   = {rem, pair};
    trial = {2'b00, root, 2'b01};
    if (cur >= trial) begin
      res.rem  = 10'(cur - trial);
      res.root = {root[SQRT_W-2:0], 1'b1};
    end else begin
      res.rem  = cur[9:0];
      res.root = {root[SQRT_W-2:0], 1'b0};
    end
    return res;
  endfunction

  function automatic logic [SQRT_W-1:0] isqrt16(input logic [RAD_W-1:0] x);
    sqrt_step_t s;
    s = '0;
    for (int i = SQRT_W - 1; i >= 0; i--) begin
      s = sqrt_step(s.rem, s.root, x[2*i +: 2]);
    end
    return s.root;
  endfunction

endpackage

// File: rtl/vec3_normalize_seq_if.sv
// Input/output handshake bundle for vec3_normalize_seq; slave is the normalizer side.
interface vec3_normalize_seq_if;
  import rayforge_q_pkg::*;

  logic                    inValid;
  logic                    inReady;
  logic signed [WIDTH-1:0] inX;
  logic signed [WIDTH-1:0] inY;
  logic signed [WIDTH-1:0] inZ;
  logic                    outValid;
  logic                    outReady;
  logic signed [WIDTH-1:0] outX;
  logic signed [WIDTH-1:0] outY;
  logic signed [WIDTH-1:0] outZ;
  logic                    zeroFlag;

  modport master (
    output inValid, inX, inY, inZ, outReady,
    input  inReady, outValid, outX, outY, outZ, zeroFlag
  );

  modport slave (
    input  inValid, inX, inY, inZ, outReady,
    output inReady, outValid, outX, outY, outZ, zeroFlag
  );

endinterface

// File: rtl/fixed_point_div.sv
// Signed Q8.4 divide by an unsigned magnitude: truncates toward zero, saturates to Q8.4.
module fixed_point_div
  import rayforge_q_pkg::*;
(
  input  logic signed [WIDTH+FRAC-1:0] num,
  input  logic        [SQRT_W-1:0]     den,
  output logic signed [WIDTH-1:0]      quo
);

  logic signed [WIDTH+FRAC:0] n_ext;
  logic signed [WIDTH+FRAC:0] d_ext;
  logic signed [WIDTH+FRAC:0] q_full;

  always_comb begin
    n_ext  = {num[WIDTH+FRAC-1], num};
    d_ext  = {{(WIDTH + FRAC + 1 - SQRT_W){1'b0}}, den};
    q_full = '0;
    if (den != '0) begin
      q_full = n_ext / d_ext;
    end
    if (q_full > MAX_Q) begin
      quo = WIDTH'(MAX_Q);
    end else if (q_full < MIN_Q) begin
      quo = WIDTH'(MIN_Q);
    end else begin
      quo = q_full[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sqrt_iter_unit.sv
// Restoring bit-pair square root, one root bit per cycle; the first step runs on the start
// cycle and done/root are combinational on the eighth, so results match isqrt16 exactly.
module sqrt_iter_unit
  import rayforge_q_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [RAD_W-1:0]  radicand,
  output logic              busy,
  output logic              done,
  output logic [SQRT_W-1:0] root
);

  logic              busy_q;
  logic [2:0]        cnt_q;
  logic [9:0]        rem_q;
  logic [SQRT_W-1:0] root_q;
  logic [RAD_W-3:0]  rad_q;
  logic [RAD_W-3:0]  rad_n;
  sqrt_step_t        step;

  always_comb begin
    if (start) begin
      step  = sqrt_step(10'd0, '0, radicand[RAD_W-1 -: 2]);
      rad_n = radicand[RAD_W-3:0];
    end else begin
      step  = sqrt_step(rem_q, root_q, rad_q[RAD_W-3 -: 2]);
      rad_n = {rad_q[RAD_W-5:0], 2'b00};
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == 3'd7);
  assign root = step.root;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      rad_q  <= '0;
    end else if (start || busy_q) begin
      busy_q <= !done;
      cnt_q  <= start ? 3'd1 : cnt_q + 3'd1;
      rem_q  <= step.rem;
      root_q <= step.root;
      rad_q  <= rad_n;
    end
  end

endmodule

// File: rtl/vec3_normalize_seq.sv
// Sequenced Q8.4 3D vector normalizer sharing one multiplier, sqrt and divider.
// Define NORMALIZE_SQRT_ITER_EN for the 8-cycle iterative root instead of the combinational one.
module vec3_normalize_seq
  import rayforge_q_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  vec3_normalize_seq_if.slave  bus
);

  state_t                  state_q, state_d;
  logic [1:0]              idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [WIDTH-1:0] vx_q, vx_d, vy_q, vy_d, vz_q, vz_d;
  logic [SQRT_W-1:0]       mag_q, mag_d;
  logic signed [WIDTH-1:0] ox_q, ox_d, oy_q, oy_d, oz_q, oz_d;
  logic                    zero_q, zero_d;

  logic signed [WIDTH-1:0]      cur_v;
  logic signed [ACC_W-1:0]      sq_prod;
  logic [10:0]                  mag2;
  logic [RAD_W-1:0]             radicand;
  logic                         root_ready;
  logic [SQRT_W-1:0]            root_val;
  logic signed [WIDTH+FRAC-1:0] div_num;
  logic signed [WIDTH-1:0]      quo;

  always_comb begin
    case (idx_q)
      2'd0:    cur_v = vx_q;
      2'd1:    cur_v = vy_q;
      default: cur_v = vz_q;
    endcase
  end

  assign sq_prod  = cur_v * cur_v;
  assign mag2     = (acc_q > ACC_W'(MAX_Q)) ? 11'(MAX_Q) : acc_q[10:0];
  assign radicand = {1'b0, mag2, {FRAC{1'b0}}};
  assign div_num  = {cur_v, {FRAC{1'b0}}};

`ifdef NORMALIZE_SQRT_ITER_EN
  logic sq_start;
  logic sq_busy;

  assign sq_start = (state_q == StRoot) && !sq_busy;

  sqrt_iter_unit u_sqrt (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (sq_start),
    .radicand (radicand),
    .busy     (sq_busy),
    .done     (root_ready),
    .root     (root_val)
  );
`else
  assign root_ready = 1'b1;
  assign root_val   = isqrt16(radicand);
`endif

  fixed_point_div u_div (
    .num (div_num),
    .den (mag_q),
    .quo (quo)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vz_d    = vz_q;
    mag_d   = mag_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    oz_d    = oz_q;
    zero_d  = zero_q;
    case (state_q)
      StIdle: begin
        if (bus.inValid) begin
          vx_d    = bus.inX;
          vy_d    = bus.inY;
          vz_d    = bus.inZ;
          acc_d   = '0;
          idx_d   = '0;
          zero_d  = 1'b0;
          state_d = StSq;
        end
      end
      StSq: begin
        // Squares are non-negative, so the arithmetic shift is a plain floor.
        acc_d = acc_q + $unsigned(sq_prod >>> FRAC);
        if (idx_q == 2'd2) begin
          idx_d   = '0;
          state_d = StRoot;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StRoot: begin
        if (root_ready) begin
          if (root_val == '0) begin
            zero_d  = 1'b1;
            ox_d    = '0;
            oy_d    = '0;
            oz_d    = '0;
            state_d = StDone;
          end else begin
            mag_d   = root_val;
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        case (idx_q)
          2'd0:    ox_d = quo;
          2'd1:    oy_d = quo;
          default: oz_d = quo;
        endcase
        if (idx_q == 2'd2) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StDone: begin
        if (bus.outReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      vz_q    <= '0;
      mag_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      oz_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vz_q    <= vz_d;
      mag_q   <= mag_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      oz_q    <= oz_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.inReady  = (state_q == StIdle);
  assign bus.outValid = (state_q == StDone);
  assign bus.outX     = ox_q;
  assign bus.outY     = oy_q;
  assign bus.outZ     = oz_q;
  assign bus.zeroFlag = zero_q;

endmodule

// File: tb/tb_vec3_normalize_seq.sv
// Self-checking bench for vec3_normalize_seq: arithmetic reference model plus directed and
// randomized vectors, checked every cycle by one negedge monitor.
module tb_vec3_normalize_seq;
  import rayforge_q_pkg::*;

`ifdef NORMALIZE_SQRT_ITER_EN
  localparam int LAT  = 15;
  localparam int LATZ = 12;
`else
  localparam int LAT  = 8;
  localparam int LATZ = 5;
`endif

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  vec3_normalize_seq_if bus ();

  vec3_normalize_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sum of floored Q8.4 squares, clamp, integer sqrt, truncating divide, clamp.
  function automatic void model(input int x, input int y, input int z, output int ox,
                                output int oy, output int oz, output int zf);
    int v[3];
    int q[3];
    int sum;
    int r;
    int m;
    v[0] = x; v[1] = y; v[2] = z;
    sum = 0;
    for (int i = 0; i < 3; i++) sum += (v[i] * v[i]) / 16;
    if (sum > 2047) sum = 2047;
    r = sum * 16;
    m = 0;
    while ((m + 1) * (m + 1) <= r) m++;
    for (int i = 0; i < 3; i++) begin
      q[i] = (m == 0) ? 0 : (v[i] * 16) / m;
      if (q[i] > 2047) q[i] = 2047;
      if (q[i] < -2048) q[i] = -2048;
    end
    ox = q[0]; oy = q[1]; oz = q[2];
    zf = (m == 0) ? 1 : 0;
  endfunction

  // Monitor state: one vector in flight at most.
  bit inflight = 0;
  bit pend_in  = 0;
  bit pend_out = 0;
  int age      = 0;
  int exp_lat  = LAT;
  int px, py, pz;
  int ex, ey, ez, ezf;

  always @(negedge clk) begin
    if (!rst_n) begin
      inflight = 0;
      pend_in  = 0;
      pend_out = 0;
      chk("rst_in_ready", 32'(bus.inReady), 1);
      chk("rst_out_valid", 32'(bus.outValid), 0);
      chk("rst_out_x", bus.outX, 0);
      chk("rst_out_y", bus.outY, 0);
      chk("rst_out_z", bus.outZ, 0);
      chk("rst_zero_flag", 32'(bus.zeroFlag), 0);
    end else begin
      if (pend_out) inflight = 0;
      if (pend_in) begin
        model(px, py, pz, ex, ey, ez, ezf);
        exp_lat  = (ezf != 0) ? LATZ : LAT;
        inflight = 1;
        age      = 1;
      end else if (inflight) begin
        age++;
      end
      chk("in_ready", 32'(bus.inReady), 32'(!inflight));
      chk("out_valid", 32'(bus.outValid), 32'(inflight && age >= exp_lat));
      if (inflight && age >= exp_lat) begin
        chk("out_x", bus.outX, ex);
        chk("out_y", bus.outY, ey);
        chk("out_z", bus.outZ, ez);
        chk("zero_flag", 32'(bus.zeroFlag), ezf);
      end else if (inflight) begin
        chk("zero_flag_busy", 32'(bus.zeroFlag), 0);
      end
      pend_in  = bus.inValid && !inflight;
      px = int'(bus.inX);
      py = int'(bus.inY);
      pz = int'(bus.inZ);
      pend_out = inflight && (age >= exp_lat) && bus.outReady;
    end
  end

  task automatic send(input int x, input int y, input int z);
    bit ok = 0;
    @(posedge clk); #1;
    bus.inValid = 1'b1;
    bus.inX = WIDTH'(x);
    bus.inY = WIDTH'(y);
    bus.inZ = WIDTH'(z);
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.inReady) ok = 1;
      @(posedge clk); #1;
    end
    bus.inValid = 1'b0;
    bus.inX = WIDTH'($urandom);
    bus.inY = WIDTH'($urandom);
    bus.inZ = WIDTH'($urandom);
    chk("accept_timeout", 32'(ok), 1);
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.outValid) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) chk("out_timeout", lat, LAT);
  endtask

  task automatic take();
    @(posedge clk); #1;
    bus.outReady = 1'b1;
    @(posedge clk); #1;
    bus.outReady = 1'b0;
  endtask

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  initial begin
    int lat;
    int mx, my, mz, mzf;

    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int mx, my, mz, mzf;
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    bus.inX = '0;
    bus.inY = '0;
    bus.inZ = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pin the reference model to hand-computed values.
    model(48, 64, 0, mx, my, mz, mzf);
    chk("model_345_x", mx, 9);
    chk("model_345_y", my, 12);
    chk("model_345_zf", mzf, 0);
    model(1600, 1600, 1600, mx, my, mz, mzf);
    chk("model_sat_z", mz, 142);
    model(0, 0, 0, mx, my, mz, mzf);
    chk("model_zero_zf", mzf, 1);

    send(48, 64, 0);
    wait_out(lat);
    chk("d1_latency", lat, LAT);
    chk("d1_x", bus.outX, 9);
    chk("d1_y", bus.outY, 12);
    chk("d1_z", bus.outZ, 0);
    chk("d1_zf", 32'(bus.zeroFlag), 0);
    take();

    send(-48, 64, 0);
    wait_out(lat);
    chk("d2_x", bus.outX, -9);
    chk("d2_y", bus.outY, 12);
    take();

    send(1600, 1600, 1600);
    wait_out(lat);
    chk("d3_x", bus.outX, 142);
    chk("d3_z", bus.outZ, 142);
    take();

    send(0, 0, 0);
    wait_out(lat);
    chk("d4_latency", lat, LATZ);
    chk("d4_x", bus.outX, 0);
    chk("d4_zf", 32'(bus.zeroFlag), 1);
    take();

    // Backpressure in DONE while new data is offered.
    send(100, -200, 300);
    wait_out(lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      bus.inValid = k[0];
      bus.inX = WIDTH'($urandom);
      bus.inY = WIDTH'($urandom);
      bus.inZ = WIDTH'($urandom);
      @(negedge clk);
      chk("hold_in_ready", 32'(bus.inReady), 0);
    end
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    take();
    chk("release_in_ready", 32'(bus.inReady), 1);

    // Reset during the divide phase aborts the vector.
    send(48, 64, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.inReady), 1);
    chk("abort_out_valid", 32'(bus.outValid), 0);
    chk("abort_out_x", bus.outX, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    send(48, 64, 0);
    wait_out(lat);
    chk("post_abort_x", bus.outX, 9);
    chk("post_abort_y", bus.outY, 12);
    take();

    for (int t = 0; t < 40; t++) begin
      int a, b, c;
      case ($urandom_range(0, 3))
        0: begin a = rnd(-40, 40); b = rnd(-40, 40); c = rnd(-40, 40); end
        1: begin a = rnd(-2048, 2047); b = rnd(-2048, 2047); c = rnd(-2048, 2047); end
        2: begin a = rnd(-3, 3); b = rnd(-3, 3); c = rnd(-3, 3); end
        default: begin a = 0; b = rnd(-2048, 2047); c = 0; end
      endcase
      send(a, b, c);
      wait_out(lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      take();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
